// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: register address width and the queued entry.
package wb_pkg;

  localparam int unsigned WB_XLEN    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of wb_entry_t with an age-ordered (oldest first) view of
// every slot so the parent can run a newest-wins bypass search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic [CW-1:0]          count_o,
  output wb_entry_t [DEPTH-1:0]  age_ent_o,
  output logic [DEPTH-1:0]       age_vld_o
);

  wb_entry_t      mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      age_ent_o[j] = mem_q[rd_ptr_q + PW'(j)];
      age_vld_o[j] = CW'(j) < count_q;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: arbitrates ALU/multiply results into an in-order FIFO and drains one
// register-file write per cycle. Bypass search is built only when WBQ_BYPASS_EN is defined.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned XLEN  = WB_XLEN,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mul_valid,
  output logic                  mul_ready,
  input  logic [REG_ADDR_W-1:0] mul_rd,
  input  logic [XLEN-1:0]       mul_data,
  input  logic                  drain_en,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] byp_rs,
  output logic                  byp_hit,
  output logic [XLEN-1:0]       byp_data,
  output logic [CW-1:0]         count
);

  logic                  not_full, alu_fire, mul_fire, push, pop;
  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] age_ent;
  logic [DEPTH-1:0]      age_vld;
  logic [CW-1:0]         fifo_count;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  // ALU has fixed priority; no enqueue while full even if a pop happens this edge.
  always_comb begin
    not_full   = fifo_count < CW'(DEPTH);
    alu_ready  = not_full;
    mul_ready  = not_full && !alu_valid;
    alu_fire   = alu_valid && alu_ready;
    mul_fire   = mul_valid && mul_ready;
    push_entry = '0;
    push       = 1'b0;
    if (alu_fire) begin
      push_entry.rd   = alu_rd;
      push_entry.data = WB_XLEN'(alu_data);
      push            = alu_rd != '0;
    end else if (mul_fire) begin
      push_entry.rd   = mul_rd;
      push_entry.data = WB_XLEN'(mul_data);
      push            = mul_rd != '0;
    end
    pop = drain_en && (fifo_count != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count),
    .age_ent_o    (age_ent),
    .age_vld_o    (age_vld)
  );

  always_comb begin
    rf_we_d    = pop;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_rd_d    = head.rd;
      rf_wdata_d = XLEN'(head.data);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = fifo_count;

`ifdef WBQ_BYPASS_EN
  // Output register first, then queue oldest to newest so the newest match wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_rs != '0) begin
      if (rf_we_q && (rf_rd_q == byp_rs)) begin
        byp_hit  = 1'b1;
        byp_data = rf_wdata_q;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (age_vld[j] && (age_ent[j].rd == byp_rs)) begin
          byp_hit  = 1'b1;
          byp_data = XLEN'(age_ent[j].data);
        end
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_rs, age_ent, age_vld};
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule
